// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx between NumReq byte sources.
//
// A winner is picked in IDLE, its byte is registered into tx_data and started with a
// one-cycle tx_enable pulse. The arbiter then waits for tx_busy to rise and fall again
// before it accepts the next byte, so at most one byte is ever in flight.
//
// Optional feature (macro UART_TX_ARB_LOCK_EN): a requester may hold the grant across
// several bytes by setting its req_lock bit on each accepted byte.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   req_valid  per-requester byte valid
//   req_data   per-requester byte, requester i in bits [8i+7:8i]
//   req_lock   per-requester grant-hold request (lock build only)
//   req_ready  accept strobe, one-hot or zero, only in IDLE
//   tx_enable  one-cycle start pulse to uart_tx
//   tx_data    byte presented to uart_tx, held until the next accept
//   tx_busy    busy flag from uart_tx
//   grant_id   index of the last accepted requester
//   arb_busy   high whenever the FSM is not in IDLE
module uart_tx_arbiter #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned IdxWidth = $clog2(NumReq)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NumReq-1:0]     req_valid,
    input  logic [8*NumReq-1:0]   req_data,
    input  logic [NumReq-1:0]     req_lock,
    output logic [NumReq-1:0]     req_ready,
    output logic                  tx_enable,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic [IdxWidth-1:0]   grant_id,
    output logic                  arb_busy
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StIssue    = 2'd1;
    localparam logic [1:0] StWaitBusy = 2'd2;
    localparam logic [1:0] StWaitDone = 2'd3;

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);

    logic [1:0]          state_q, state_d;
    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic [IdxWidth-1:0] grant_id_q, grant_id_d;
    logic [7:0]          tx_data_q, tx_data_d;

    logic [NumReq-1:0]   cand;
    logic                found;
    logic [IdxWidth-1:0] winner;
    logic [IdxWidth-1:0] idx;
    logic [IdxWidth-1:0] next_ptr;
    logic [7:0]          win_byte;
    logic                grant;

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;

    // While locked only the current owner may be granted.
    always_comb begin
        cand = req_valid;
        if (lock_q) begin
            cand = req_valid & (NumReq'(1) << grant_id_q);
        end
    end
`else
    logic unused_req_lock;
    assign unused_req_lock = ^req_lock;
    assign cand = req_valid;
`endif

    // Rotating search starting at ptr_q; explicit wrap so non-power-of-2 NumReq works.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = ptr_q;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = (idx == LastIdx) ? '0 : idx + IdxWidth'(1);
        end
    end

    always_comb begin
        win_byte = 8'h00;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (winner == IdxWidth'(k)) begin
                win_byte = req_data[8*k +: 8];
            end
        end
    end

    assign next_ptr = (winner == LastIdx) ? '0 : winner + IdxWidth'(1);

    // Gated by reset so a byte is never acknowledged in a cycle that clears the state.
    assign grant = (state_q == StIdle) && !tx_busy && found && !reset;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d     = lock_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d    = StIssue;
                    grant_id_d = winner;
                    tx_data_d  = win_byte;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d = req_lock[winner];
                    // Rotation resumes only on the unlocking byte.
                    if (!req_lock[winner]) begin
                        ptr_d = next_ptr;
                    end
`else
                    ptr_d = next_ptr;
`endif
                end
            end
            StIssue:    state_d = StWaitBusy;
            StWaitBusy: if (tx_busy) state_d = StWaitDone;
            StWaitDone: if (!tx_busy) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_id_q <= '0;
            tx_data_q  <= 8'h00;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign req_ready = grant ? (NumReq'(1) << winner) : '0;
    assign tx_enable = (state_q == StIssue);
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign arb_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: behavioural uart_tx model (4 clocks per bit), a
// transaction-level reference model of the arbiter, directed scenarios and a random phase.
// A second NumReq=3 instance checks the non-power-of-2 wrap.
module tb_uart_tx_arbiter;

    localparam int NumReq   = 4;
    localparam int IdxWidth = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NumReq-1:0]     req_valid;
    logic [8*NumReq-1:0]   req_data;
    logic [NumReq-1:0]     req_lock;
    logic [NumReq-1:0]     req_ready;
    logic                  tx_enable;
    logic [7:0]            tx_data;
    logic                  tx_busy;
    logic [IdxWidth-1:0]   grant_id;
    logic                  arb_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NumReq(NumReq)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_ready(req_ready), .tx_enable(tx_enable),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id), .arb_busy(arb_busy)
    );

    // uart_tx model: loads on tx_enable, busy from the next cycle for 10 bits x 4 clocks.
    logic       u_busy;
    logic [5:0] u_e;
    logic [9:0] u_frame, u_seen, last_frame;
    logic       busy_force;
    logic       u_line;

    assign tx_busy = u_busy | busy_force;
    assign u_line  = u_busy ? u_frame[u_e[5:2]] : 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            u_busy <= 1'b0;
            u_e    <= '0;
        end else if (u_busy) begin
            if (u_e[1:0] == 2'd2) u_seen[u_e[5:2]] <= u_line;
            if (u_e == 6'd39) begin
                u_busy     <= 1'b0;
                last_frame <= u_seen;
            end
            u_e <= u_e + 6'd1;
        end else if (tx_enable) begin
            u_busy  <= 1'b1;
            u_e     <= '0;
            u_frame <= {1'b1, tx_data, 1'b0};
        end
    end

    // NumReq=3 instance, all requesters always valid, byte of requester i is i+1.
    logic       rst3;
    logic [2:0] v3_ready;
    logic       v3_en, v3_arb, v3_busy;
    logic [7:0] v3_data;
    logic [1:0] v3_gid;
    int         v3_cnt;

    uart_tx_arbiter #(.NumReq(3)) dut3 (
        .clk(clk), .reset(rst3), .req_valid(3'b111), .req_data(24'h030201),
        .req_lock(3'b000), .req_ready(v3_ready), .tx_enable(v3_en), .tx_data(v3_data),
        .tx_busy(v3_busy), .grant_id(v3_gid), .arb_busy(v3_arb)
    );

    always @(posedge clk) begin
        if (rst3) begin
            v3_busy <= 1'b0;
            v3_cnt  <= 0;
        end else if (v3_en) begin
            v3_busy <= 1'b1;
            v3_cnt  <= 5;
        end else if (v3_busy) begin
            if (v3_cnt == 0) v3_busy <= 1'b0;
            else v3_cnt <= v3_cnt - 1;
        end
    end

    // Bookkeeping
    int n_cmp = 0;
    int n_err = 0;
    int last_acc;
    int acc_log[$];
    int v3_log[$];
    int v3_last = 0;

    // Reference model state
    bit       m_idle, m_issue, m_wait, m_seen, m_lock;
    int       m_ptr, m_grant;
    bit [7:0] m_data;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NumReq-1:0] cand, input int ptr);
        for (int k = 0; k < NumReq; k++) begin
            if (cand[(ptr + k) % NumReq]) return (ptr + k) % NumReq;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_idle = 1; m_issue = 0; m_wait = 0; m_seen = 0; m_lock = 0;
        m_ptr = 0; m_grant = 0; m_data = 8'h00;
    endfunction

    // Runs at the falling edge: compare outputs, then advance the model past the next edge.
    task automatic model_step();
        logic [NumReq-1:0] cand, exp_ready;
        int w;
        cand = req_valid;
`ifdef UART_TX_ARB_LOCK_EN
        if (m_lock) cand = req_valid & NumReq'(1 << m_grant);
`endif
        w = -1;
        exp_ready = '0;
        if (!reset && m_idle && !tx_busy) w = pick(cand, m_ptr);
        if (w >= 0) exp_ready[w] = 1'b1;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("tx_enable", tx_enable, m_issue);
        check_eq("arb_busy", arb_busy, !m_idle);
        check_eq("grant_id", grant_id, m_grant);
        check_eq("tx_data", tx_data, m_data);
        last_acc = -1;
        for (int i = 0; i < NumReq; i++) if (req_ready[i] && req_valid[i]) last_acc = i;

        if (reset) begin
            model_reset();
        end else begin
            if (m_issue) begin
                m_issue = 0; m_wait = 1; m_seen = 0;
            end else if (m_wait) begin
                if (!m_seen) begin
                    if (tx_busy) m_seen = 1;
                end else if (!tx_busy) begin
                    m_wait = 0; m_idle = 1;
                end
            end
            if (w >= 0) begin
                m_idle = 0; m_issue = 1; m_grant = w;
                m_data = req_data[8*w +: 8];
`ifdef UART_TX_ARB_LOCK_EN
                m_lock = req_lock[w];
                if (!req_lock[w]) m_ptr = (w + 1) % NumReq;
`else
                m_ptr = (w + 1) % NumReq;
`endif
            end
        end

        if (!rst3) begin
            check_eq("n3_onehot", ($countones(v3_ready) <= 1), 1);
            for (int i = 0; i < 3; i++) begin
                if (v3_ready[i]) begin
                    v3_log.push_back(i);
                    v3_last = i;
                end
            end
            if (v3_en) check_eq("n3_tx_data", v3_data, v3_last + 1);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    task automatic run_until_acc(input int budget, output int idx);
        idx = -1;
        for (int n = 0; n < budget && idx < 0; n++) begin
            cycle();
            idx = last_acc;
        end
        check_eq("acc_seen", (idx >= 0), 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget && arb_busy; n++) cycle();
        check_eq("idle_seen", !arb_busy, 1);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int n = 0; n < cycles; n++) cycle();
        reset = 1'b0;
    endtask

    int exp2[5] = '{0, 1, 2, 3, 0};
    int exp5[4] = '{0, 1, 2, 0};
    int expl[4];
    int exp_line[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        int a;
        int l_idx;
        int quiet;
        reset = 1'b1; rst3 = 1'b1; busy_force = 1'b0;
        req_valid = '0; req_lock = '0; req_data = '0;
        model_reset();

        // All four valid continuously from reset
        req_valid = '1;
        for (int i = 0; i < NumReq; i++) set_byte(i, 8'($urandom));
        do_reset(2);
        acc_log.delete();
        for (int n = 0; n < 400 && acc_log.size() < 5; n++) begin
            cycle();
            if (last_acc >= 0) begin
                acc_log.push_back(last_acc);
                set_byte(last_acc, 8'($urandom));
            end
        end
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("rr_order%0d", k), (acc_log.size() > k) ? acc_log[k] : -1, exp2[k]);

        // Single request from requester 2, byte A5, serial frame check
        req_valid = '0;
        do_reset(2);
        req_valid = 4'b0100;
        set_byte(2, 8'hA5);
        run_until_acc(50, a);
        check_eq("single_idx", a, 2);
        req_valid = '0;
        cycle();
        check_eq("single_grant", grant_id, 2);
        wait_idle(100);
        for (int b = 0; b < 10; b++)
            check_eq($sformatf("single_line%0d", b), last_frame[b], exp_line[b]);

        // tx_busy held high while idle blocks any grant
        busy_force = 1'b1;
        req_valid  = 4'b0001;
        set_byte(0, 8'h3C);
        quiet = 0;
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (req_ready != '0) quiet++;
        end
        check_eq("busy_block", quiet, 0);
        busy_force = 1'b0;
        run_until_acc(10, a);
        check_eq("busy_release_idx", a, 0);
        req_valid = '0;
        wait_idle(100);

        // Reset mid-frame, then ptr must restart at 0
        req_valid = 4'b0010;
        set_byte(1, 8'h5A);
        run_until_acc(10, a);
        req_valid = '0;
        for (int n = 0; n < 15; n++) cycle();
        reset = 1'b1;
        cycle();
        cycle();
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_enable", tx_enable, 0);
        check_eq("rst_data", tx_data, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_busy", arb_busy, 0);
        reset = 1'b0;
        req_valid = 4'b1010;
        set_byte(1, 8'h11);
        set_byte(3, 8'h33);
        run_until_acc(10, a);
        check_eq("post_rst_first", a, 1);
        req_valid[1] = 1'b0;
        run_until_acc(100, a);
        check_eq("post_rst_req3", a, 3);
        req_valid = '0;
        wait_idle(100);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            cycle();
            if (last_acc >= 0) req_valid[last_acc] = 1'b0;
            for (int i = 0; i < NumReq; i++) begin
                if (!req_valid[i] && ($urandom % 4 == 0)) begin
                    req_valid[i] = 1'b1;
                    set_byte(i, 8'($urandom));
                    req_lock[i] = 1'($urandom % 2);
                end else if (req_valid[i] && ($urandom % 24 == 0)) begin
                    req_valid[i] = 1'b0;
                end
            end
            busy_force = (($urandom % 16) == 0) && !arb_busy;
            reset = (($urandom % 500) == 0);
        end
        reset = 1'b0;
        busy_force = 1'b0;
        req_valid = '0;
        req_lock = '0;

        // Lock scenario: requester 1 sends three bytes (lock 1,1,0) while requester 0 waits
        do_reset(2);
        req_valid = 4'b0001;
        set_byte(0, 8'h01);
        run_until_acc(10, a);
        req_valid = '0;
        wait_idle(100);
`ifdef UART_TX_ARB_LOCK_EN
        expl = '{1, 1, 1, 0};
`else
        expl = '{1, 0, 1, 1};
`endif
        req_valid = 4'b0011;
        set_byte(0, 8'h10);
        set_byte(1, 8'h21);
        req_lock[1] = 1'b1;
        l_idx = 0;
        acc_log.delete();
        for (int n = 0; n < 600 && acc_log.size() < 4; n++) begin
            cycle();
            if (last_acc >= 0) acc_log.push_back(last_acc);
            if (last_acc == 1) begin
                l_idx++;
                if (l_idx < 3) begin
                    set_byte(1, 8'(8'h21 + l_idx));
                    req_lock[1] = (l_idx < 2);
                end else begin
                    req_valid[1] = 1'b0;
                end
            end else if (last_acc == 0) begin
                req_valid[0] = 1'b0;
            end
        end
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("lock_order%0d", k), (acc_log.size() > k) ? acc_log[k] : -1, expl[k]);
        req_lock = '0;

        // NumReq=3 wrap
        rst3 = 1'b0;
        for (int n = 0; n < 200 && v3_log.size() < 4; n++) cycle();
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("n3_order%0d", k), (v3_log.size() > k) ? v3_log[k] : -1, exp5[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
